sar_adc_seq: RTL and testbench

- Channel sequencer and result collector that sits directly downstream of, and controls, the parametrized SAR conversion core.
- Each scan walks the enabled analog mux channels in ascending order, waits a mux settle time, and pulses the SAR start.
- On each SAR done it captures the SAR output and optionally averages 1/2/4/8 samples per channel.
- It posts per-channel results into a register bank read by the register/bus interface.

---
 rtl/sar_adc_seq.sv | 177 +++++++++++++++++
 tb/tb_sar_adc_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_seq.sv
// sar_adc_seq: scans enabled mux channels, drives the SAR core, averages 2^cfg_avg samples per channel and posts results into a per-channel bank
module sar_adc_seq #(
  parameter int SIZE = 8,
  parameter int NCH = 6,
  parameter int CHW = 3,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_en,
  input  logic [NCH-1:0]      cfg_ch_mask,
  input  logic [1:0]          cfg_avg,
  input  logic                cfg_cont,
  input  logic                sw_trig,
  output logic                sar_start,
  input  logic                sar_done,
  input  logic [SIZE-1:0]     sar_out,
  output logic [CHW-1:0]      ch_sel,
  output logic                busy,
  output logic                res_valid,
  output logic [CHW-1:0]      res_ch,
  output logic [SIZE-1:0]     res_data,
  output logic [NCH*SIZE-1:0] res_bank,
  output logic                seq_done
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT, S_POST} state_t;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
  state_t              state, state_n;
  logic [NCH-1:0]      smask, smask_n;
  logic [1:0]          savg, savg_n;
  logic                scont, scont_n;
  logic [3:0]          scnt, scnt_n;
  logic [3:0]          cnt, cnt_n, cnt_inc;
  logic [SIZE+2:0]     acc, acc_n, sum;
  logic [SIZE-1:0]     avg_res;
  logic [CHW-1:0]      nxt_ch, first_ch, ch_sel_n, res_ch_n;
  logic                has_next, go;
  logic                busy_n, sar_start_n, res_valid_n, seq_done_n;
  logic [SIZE-1:0]     res_data_n;
  logic [NCH*SIZE-1:0] res_bank_n;
  assign go = cfg_en && |cfg_ch_mask;
  always_comb begin
    sum = acc + {3'b000, sar_out};
    avg_res = SIZE'(sum >> savg);
    cnt_inc = cnt + 4'd1;
    has_next = 1'b0;
    nxt_ch = '0;
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (smask[i] && CHW'(i) > ch_sel) begin
        has_next = 1'b1;
        nxt_ch = CHW'(i);
      end
      if (cfg_ch_mask[i]) first_ch = CHW'(i);
    end
  end
  always_comb begin
    state_n = state;
    smask_n = smask;
    savg_n = savg;
    scont_n = scont;
    scnt_n = scnt;
    cnt_n = cnt;
    acc_n = acc;
    ch_sel_n = ch_sel;
    busy_n = busy;
    sar_start_n = 1'b0;
    res_valid_n = 1'b0;
    seq_done_n = 1'b0;
    res_ch_n = res_ch;
    res_data_n = res_data;
    res_bank_n = res_bank;
    case (state)
      S_IDLE: if (sw_trig && go) begin
        state_n = S_SETTLE;
        smask_n = cfg_ch_mask;
        savg_n = cfg_avg;
        scont_n = cfg_cont;
        ch_sel_n = first_ch;
        scnt_n = '0;
        busy_n = 1'b1;
      end
      S_SETTLE: if (!cfg_en) begin
        state_n = S_IDLE;
        busy_n = 1'b0;
      end else if (scnt == SETTLE_LAST) begin
        state_n = S_START;
        sar_start_n = 1'b1;
      end else begin
        scnt_n = scnt + 4'd1;
      end
      S_START: begin
        state_n = cfg_en ? S_WAIT : S_IDLE;
        busy_n = cfg_en;
      end
      S_WAIT: if (sar_done) begin
        acc_n = '0;
        cnt_n = '0;
        if (!cfg_en) begin
          state_n = S_IDLE;
          busy_n = 1'b0;
        end else if (cnt_inc < (4'd1 << savg)) begin
          acc_n = sum;
          cnt_n = cnt_inc;
          state_n = S_START;
          sar_start_n = 1'b1;
        end else begin
          state_n = S_POST;
          res_valid_n = 1'b1;
          res_ch_n = ch_sel;
          res_data_n = avg_res;
          seq_done_n = !has_next;
          for (int i = 0; i < NCH; i++)
            if (CHW'(i) == ch_sel) res_bank_n[i*SIZE +: SIZE] = avg_res;
        end
      end
      S_POST: if (has_next) begin
        state_n = S_SETTLE;
        ch_sel_n = nxt_ch;
        scnt_n = '0;
      end else if (scont && go) begin
        state_n = S_SETTLE;
        smask_n = cfg_ch_mask;
        savg_n = cfg_avg;
        scont_n = cfg_cont;
        ch_sel_n = first_ch;
        scnt_n = '0;
      end else begin
        state_n = S_IDLE;
        busy_n = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        busy_n = 1'b0;
      end
    endcase
    if (state_n == S_IDLE) begin
      acc_n = '0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      smask <= '0;
      savg <= '0;
      scont <= 1'b0;
      scnt <= '0;
      cnt <= '0;
      acc <= '0;
      ch_sel <= '0;
      busy <= 1'b0;
      sar_start <= 1'b0;
      res_valid <= 1'b0;
      seq_done <= 1'b0;
      res_ch <= '0;
      res_data <= '0;
      res_bank <= '0;
    end else begin
      state <= state_n;
      smask <= smask_n;
      savg <= savg_n;
      scont <= scont_n;
      scnt <= scnt_n;
      cnt <= cnt_n;
      acc <= acc_n;
      ch_sel <= ch_sel_n;
      busy <= busy_n;
      sar_start <= sar_start_n;
      res_valid <= res_valid_n;
      seq_done <= seq_done_n;
      res_ch <= res_ch_n;
      res_data <= res_data_n;
      res_bank <= res_bank_n;
    end
  end
endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: randomized scans against a behavioural SAR core and an arithmetic model of per-channel averaged results
module tb_sar_adc_seq;
  localparam int SIZE = 8, NCH = 6, CHW = 3, SETTLE = 2;
  localparam int SL = SETTLE == 0 ? 1 : SETTLE;
  typedef struct {logic [CHW-1:0] ch; logic [SIZE-1:0] data; logic last;} post_t;
  logic clk = 0, reset = 1, cfg_en = 0, cfg_cont = 0, sw_trig = 0, sar_done = 0;
  logic [NCH-1:0] cfg_ch_mask = '0;
  logic [1:0] cfg_avg = '0;
  logic [SIZE-1:0] sar_out = '0;
  logic sar_start, busy, res_valid, seq_done;
  logic [CHW-1:0] ch_sel, res_ch;
  logic [SIZE-1:0] res_data;
  logic [NCH*SIZE-1:0] res_bank;
  int n_chk = 0, n_err = 0, cyc = 0, starts = 0, posts = 0, seqs = 0, dones = 0;
  int mark = 0, lat_lo = 0, lat_hi = 4, sar_lat = 0;
  logic need_settle = 0, prev_busy = 0, sar_pend = 0;
  logic [7:0] m_mask = '0;
  logic [SIZE-1:0] m_bank [NCH];
  logic [SIZE-1:0] sar_q [$];
  post_t exp_q [$];
  sar_adc_seq #(.SIZE(SIZE), .NCH(NCH), .CHW(CHW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_ch_mask(cfg_ch_mask), .cfg_avg(cfg_avg),
    .cfg_cont(cfg_cont), .sw_trig(sw_trig), .sar_start(sar_start), .sar_done(sar_done),
    .sar_out(sar_out), .ch_sel(ch_sel), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .res_bank(res_bank), .seq_done(seq_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    post_t e;
    if (reset) begin
      need_settle = 0;
      prev_busy = 0;
      sar_pend = 0;
      sar_done = 0;
    end else begin
      if (busy && !prev_busy) begin
        need_settle = 1;
        mark = cyc;
      end
      if (sar_start) begin
        starts++;
        if (exp_q.size() != 0) chk("start_ch", 64'(ch_sel), 64'(exp_q[0].ch));
        if (need_settle) chk("settle_cycles", 64'(cyc - mark), 64'(SL));
        else chk("no_settle_between_samples", 64'(sar_done), 64'd1);
        need_settle = 0;
      end
      if (busy) chk("ch_sel_enabled", 64'(m_mask[ch_sel]), 64'd1);
      if (res_valid) begin
        posts++;
        if (exp_q.size() == 0) chk("post_unexpected", 64'(res_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("res_ch", 64'(res_ch), 64'(e.ch));
          chk("res_data", 64'(res_data), 64'(e.data));
          chk("bank_slot", 64'(res_bank[e.ch*SIZE +: SIZE]), 64'(e.data));
          chk("seq_done", 64'(seq_done), 64'(e.last));
        end
        need_settle = 1;
        mark = cyc + 1;
      end else if (seq_done) chk("seq_without_post", 64'(res_valid), 64'd1);
      if (seq_done) seqs++;
      sar_done = 0;
      if (sar_pend) begin
        if (sar_lat == 0) begin
          sar_done = 1;
          dones++;
          sar_pend = 0;
          if (sar_q.size() != 0) sar_out = sar_q.pop_front();
          else sar_out = SIZE'($urandom);
        end else sar_lat--;
      end
      if (sar_start) begin
        sar_pend = 1;
        sar_lat = $urandom_range(lat_hi, lat_lo);
      end
      prev_busy = busy;
    end
  end
  task automatic cfg(input logic [NCH-1:0] m, input logic [1:0] a, input logic c);
    cfg_en = 1;
    cfg_ch_mask = m;
    cfg_avg = a;
    cfg_cont = c;
    m_mask = 8'(m);
  endtask
  task automatic plan_scan(input logic [NCH-1:0] m, input int avg);
    int hi, sum, v;
    hi = 0;
    for (int c = 0; c < NCH; c++) if (m[c]) hi = c;
    for (int c = 0; c < NCH; c++) if (m[c]) begin
      sum = 0;
      for (int k = 0; k < (1 << avg); k++) begin
        v = $urandom_range(255, 0);
        sar_q.push_back(SIZE'(v));
        sum += v;
      end
      exp_q.push_back('{ch: CHW'(c), data: SIZE'(sum >> avg), last: c == hi});
      m_bank[c] = SIZE'(sum >> avg);
    end
  endtask
  task automatic trig();
    @(negedge clk);
    sw_trig = 1;
    @(negedge clk);
    sw_trig = 0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 64'(busy), 64'd0);
  endtask
  task automatic finish_scan();
    wait_idle(3000);
    chk("expected_posts_drained", 64'(exp_q.size()), 64'd0);
    chk("sar_samples_drained", 64'(sar_q.size()), 64'd0);
  endtask
  task automatic bank_chk();
    for (int c = 0; c < NCH; c++)
      chk($sformatf("bank_ch%0d", c), 64'(res_bank[c*SIZE +: SIZE]), 64'(m_bank[c]));
  endtask
  task automatic zero_chk(input string p);
    chk({p, "_sar_start"}, 64'(sar_start), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({p, "_seq_done"}, 64'(seq_done), 64'd0);
    chk({p, "_ch_sel"}, 64'(ch_sel), 64'd0);
    chk({p, "_res_ch"}, 64'(res_ch), 64'd0);
    chk({p, "_res_data"}, 64'(res_data), 64'd0);
    chk({p, "_res_bank"}, 64'(res_bank), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    int s0, q0, p0, d0, n;
    logic [NCH-1:0] m;
    for (int c = 0; c < NCH; c++) m_bank[c] = '0;
    repeat (3) @(negedge clk);
    zero_chk("por");
    reset = 0;
    cfg(6'b000001, 2'd0, 1'b0);
    sar_q.push_back(8'hA5);
    exp_q.push_back('{ch: 3'd0, data: 8'hA5, last: 1'b1});
    m_bank[0] = 8'hA5;
    s0 = starts;
    trig();
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t1_post", 64'(res_valid), 64'd1);
    chk("t1_seq_same_cycle", 64'(seq_done), 64'd1);
    @(negedge clk);
    chk("t1_busy_fall", 64'(busy), 64'd0);
    chk("t1_starts", 64'(starts - s0), 64'd1);
    cfg(6'b000100, 2'd2, 1'b0);
    sar_q.push_back(8'd10);
    sar_q.push_back(8'd11);
    sar_q.push_back(8'd12);
    sar_q.push_back(8'd14);
    exp_q.push_back('{ch: 3'd2, data: 8'd11, last: 1'b1});
    m_bank[2] = 8'd11;
    s0 = starts;
    trig();
    finish_scan();
    chk("t2_starts", 64'(starts - s0), 64'd4);
    chk("t2_bank2", 64'(res_bank[2*SIZE +: SIZE]), 64'd11);
    cfg(6'b101010, 2'($urandom_range(1, 0)), 1'b0);
    plan_scan(6'b101010, int'(cfg_avg));
    trig();
    finish_scan();
    bank_chk();
    repeat (6) begin
      m = NCH'($urandom_range((1 << NCH) - 1, 1));
      cfg(m, 2'($urandom_range(3, 0)), 1'b0);
      plan_scan(m, int'(cfg_avg));
      trig();
      finish_scan();
      bank_chk();
    end
    cfg(6'b000000, 2'd0, 1'b0);
    s0 = starts;
    trig();
    repeat (10) @(negedge clk);
    chk("mask0_busy", 64'(busy), 64'd0);
    chk("mask0_starts", 64'(starts - s0), 64'd0);
    cfg(6'b000011, 2'd0, 1'b0);
    cfg_en = 0;
    trig();
    repeat (10) @(negedge clk);
    chk("en0_busy", 64'(busy), 64'd0);
    chk("en0_starts", 64'(starts - s0), 64'd0);
    lat_lo = 4;
    cfg(6'b000011, 2'd1, 1'b0);
    plan_scan(6'b000011, 1);
    q0 = seqs;
    s0 = starts;
    trig();
    repeat (2) begin
      repeat (4) @(negedge clk);
      if (busy) trig();
    end
    finish_scan();
    chk("busy_trig_seqs", 64'(seqs - q0), 64'd1);
    chk("busy_trig_starts", 64'(starts - s0), 64'd4);
    repeat (10) @(negedge clk);
    chk("busy_trig_not_queued", 64'(starts - s0), 64'd4);
    lat_lo = 0;
    cfg(6'b000011, 2'($urandom_range(2, 0)), 1'b1);
    plan_scan(6'b000011, int'(cfg_avg));
    plan_scan(6'b000011, int'(cfg_avg));
    trig();
    n = 0;
    q0 = 0;
    while (q0 < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (seq_done) q0++;
    end
    chk("cont_two_scans", 64'(q0), 64'd2);
    n = 0;
    while (!sar_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cont_restart_start", 64'(sar_start), 64'd1);
    chk("cont_busy_held", 64'(busy), 64'd1);
    d0 = dones;
    p0 = posts;
    q0 = seqs;
    @(negedge clk);
    cfg_en = 0;
    wait_idle(200);
    chk("abort_conversion_completes", 64'(dones - d0), 64'd1);
    chk("abort_no_post", 64'(posts - p0), 64'd0);
    chk("abort_no_seq_done", 64'(seqs - q0), 64'd0);
    s0 = starts;
    repeat (20) @(negedge clk);
    chk("abort_no_start", 64'(starts - s0), 64'd0);
    chk("abort_expected_drained", 64'(exp_q.size()), 64'd0);
    m = NCH'(1) << $urandom_range(NCH - 1, 0);
    cfg(m, 2'd3, 1'b0);
    plan_scan(m, 3);
    trig();
    n = 0;
    q0 = 0;
    while (q0 < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (sar_start) q0++;
    end
    chk("rst_reach_wait", 64'(q0), 64'd3);
    @(negedge clk);
    reset = 1;
    #1;
    zero_chk("mid_rst");
    sar_q.delete();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) m_bank[c] = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    plan_scan(m, 3);
    trig();
    finish_scan();
    bank_chk();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
